security_event_controller: RTL
==============================

# security_event_controller

Sequencing controller for the security system. It latches events from the calamity sensors (fire, earthquake), the four zone outputs of the security signal distributor and the employee access comparator. It arbitrates them by priority and round-robin onto a single server reporting channel with a req/ack handshake. It also owns access lockout after repeated code failures and drives the building alarm and fire-exit outputs.

## Interface
- ACK_TIMEOUT, 15: max cycles srv_req stays high awaiting srv_ack (>=1)
- MAX_FAIL, 3: consecutive code mismatches that trigger lockout (>=1)
- LOCK_CYCLES, 64: lockout duration in cycles (>=1)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- fire  in  1  fire sensor level
- quake  in  1  earthquake sensor level
- zone_req  in  4  distributor zone levels s0..s3 (bit i = zone i)
- code_valid  in  1  one-cycle strobe: employee code presented
- code_match  in  1  comparator result, sampled only with code_valid
- srv_ack  in  1  server accepts current event
- srv_req  out  1  event offered to server
- srv_event  out  3  event code: 0-3 zone i, 4 fire, 5 quake, 6 lockout, 7 unused
- alarm  out  1  calamity active (drives fire alarm / dept alert)
- exit_open  out  1  fire exits released; equals alarm
- door_unlock  out  1  one-cycle pulse on accepted code
- locked  out  1  access lockout active
- retry_err  out  1  sticky: a server request timed out

## Operation
- Edge detect: prev registers for fire, quake, zone_req. Rise (in=1, prev=0) at edge N sets pend bit at edge N. Pend bits: zone0-3, fire, quake, lockout.
- Pend bit clears only on srv_ack for that event. A new rise on the same source at the clear edge leaves it set.
- FSM states IDLE, REQ, GAP.
  - IDLE: any pend -> REQ; select event, latch into srv_event.
  - REQ: srv_req=1, srv_event held stable. srv_ack -> clear bit, clear retry_err, -> GAP. Timeout -> set retry_err, bit stays pending, -> GAP.
  - GAP: srv_req=0 one cycle; any pend -> REQ (new selection) else IDLE.
- Selection priority: quake > fire > lockout > zones. Zones are round-robin starting at rr_ptr. rr_ptr = granted zone+1 mod 4, updated on ack or timeout of a zone event.
- alarm = registered (fire | quake) OR pend[fire] OR pend[quake].
- Access:
  - code_valid while locked: ignored.
  - Unlocked, match: door_unlock pulses next cycle, fail_cnt cleared.
  - Unlocked, mismatch: fail_cnt+1. Reaching MAX_FAIL -> locked=1, lock_cnt=LOCK_CYCLES, pend[lockout] set, fail_cnt cleared.
  - Lockout duration: lock_cnt decrements each cycle; locked drops when lock_cnt reaches 0.
- Widths: fail_cnt $clog2(MAX_FAIL+1), lock_cnt $clog2(LOCK_CYCLES+1), timeout counter $clog2(ACK_TIMEOUT+1); no wrap possible.

## Timing
- Reset (async) values: all outputs 0, state IDLE, all pend/prev/counters 0, rr_ptr=0.
- Reset mid-REQ drops srv_req immediately. Inputs high at reset release produce rises at the first edge.
- Event latency: rise at edge N -> pend at N -> srv_req high after edge N+1.
- srv_ack is sampled only in REQ; ack outside REQ is ignored.
- srv_req falls after the ack edge. Back-to-back events have exactly one low cycle (GAP).
- Timeout: srv_req high at most ACK_TIMEOUT cycles. An ack on the last cycle wins over the timeout.
- alarm rises one edge after fire/quake rise. It falls the edge after both inputs are low and the pending calamity events are acked.
- door_unlock: strobe at edge N -> high for cycle N..N+1 only.
- Lockout: locked high for exactly LOCK_CYCLES cycles. The lockout event is reported through the FSM like any other event.
- Simultaneous fire and quake rise: quake reported first, fire next after GAP.

## Test plan
- Reset: all outputs 0. Zone 2 rises -> srv_req=1, srv_event=2 two edges later. Ack -> req low 1 cycle, then idle.
- zone_req=4'b1111 rise together, ack each immediately -> srv_event sequence 0,1,2,3. Repeat with rr_ptr=2 -> 2,3,0,1.
- Zone 1 pending, then fire and quake rise in the same cycle -> 5, 4, then 1. alarm=exit_open=1 until both calamity inputs are low and both events are acked.
- Three mismatches with MAX_FAIL=3 -> locked=1 for 64 cycles and event 6 reported. A match during lockout -> no door_unlock. A match after lockout -> one-cycle door_unlock.
- Never ack with ACK_TIMEOUT=15 -> srv_req high 15 cycles, retry_err=1, same event re-offered after GAP. Ack -> retry_err cleared.
- Assert rst during REQ -> srv_req and all pend clear immediately. Zone input held high through reset release -> event reported again.

Source files
------------

// File: rtl/security_event_controller.sv
// Security event sequencer: latches sensor/zone/lockout events, reports them one at a
// time over a req/ack channel, and manages the access-code lockout and calamity outputs.
module security_event_controller #(
    parameter int ACK_TIMEOUT = 15,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fire,
    input  logic       quake,
    input  logic [3:0] zone_req,
    input  logic       code_valid,
    input  logic       code_match,
    input  logic       srv_ack,
    output logic       srv_req,
    output logic [2:0] srv_event,
    output logic       alarm,
    output logic       exit_open,
    output logic       door_unlock,
    output logic       locked,
    output logic       retry_err
);

    localparam int TMO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
    localparam logic [LOCK_W-1:0] LOCK_INIT = LOCK_W'(LOCK_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

    localparam int EV_FIRE  = 4;
    localparam int EV_QUAKE = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t            state_q;
    logic              srv_req_q;
    logic [2:0]        srv_event_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic [1:0]        rr_ptr_q;
    logic              retry_err_q;

    logic [5:0]        prev_q;
    logic [5:0]        src_now;
    logic [5:0]        rise;
    logic [6:0]        pend_q;
    logic [6:0]        pend_d;
    logic [6:0]        set_vec;
    logic [6:0]        clr_vec;
    logic              ack_take;

    logic [FAIL_W-1:0] fail_cnt_q;
    logic [LOCK_W-1:0] lock_cnt_q;
    logic              locked_q;
    logic              door_unlock_q;
    logic              lock_set;

    logic [2:0]        sel_code;
    logic              sel_any;
    logic [3:0]        zone_pend;

    // Source order matches event codes: zones 0-3, fire 4, quake 5.
    assign src_now = {quake, fire, zone_req};

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_rise
            assign rise[gi] = src_now[gi] & ~prev_q[gi];
        end
    endgenerate

    assign ack_take = (state_q == S_REQ) && srv_ack;
    assign lock_set = code_valid && !locked_q && !code_match && (fail_cnt_q == FAIL_LAST);
    assign set_vec  = {lock_set, rise};

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_clr
            assign clr_vec[gi] = ack_take && (srv_event_q == 3'(gi));
        end
    endgenerate

    // A fresh rise on the edge that acks the same source keeps it pending.
    assign pend_d = (pend_q & ~clr_vec) | set_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            pend_q <= '0;
        end else begin
            prev_q <= src_now;
            pend_q <= pend_d;
        end
    end

    assign zone_pend = pend_q[3:0];
    assign sel_any   = |pend_q;

    always_comb begin
        logic [1:0] zi;
        zi       = 2'd0;
        sel_code = 3'd0;
        if (pend_q[EV_QUAKE]) begin
            sel_code = 3'd5;
        end else if (pend_q[EV_FIRE]) begin
            sel_code = 3'd4;
        end else if (pend_q[6]) begin
            sel_code = 3'd6;
        end else begin
            // Descending scan so the zone closest to rr_ptr wins.
            for (int k = 3; k >= 0; k--) begin
                zi = rr_ptr_q + 2'(k);
                if (zone_pend[zi]) begin
                    sel_code = {1'b0, zi};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            srv_req_q   <= 1'b0;
            srv_event_q <= 3'd0;
            tmo_cnt_q   <= '0;
            rr_ptr_q    <= 2'd0;
            retry_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_GAP: begin
                    if (sel_any) begin
                        state_q     <= S_REQ;
                        srv_req_q   <= 1'b1;
                        srv_event_q <= sel_code;
                        tmo_cnt_q   <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (srv_ack || (tmo_cnt_q == TMO_LAST)) begin
                        state_q     <= S_GAP;
                        srv_req_q   <= 1'b0;
                        retry_err_q <= !srv_ack;
                        if (!srv_event_q[2]) begin
                            rr_ptr_q <= srv_event_q[1:0] + 2'd1;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    srv_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_cnt_q    <= '0;
            lock_cnt_q    <= '0;
            locked_q      <= 1'b0;
            door_unlock_q <= 1'b0;
        end else begin
            door_unlock_q <= 1'b0;
            if (locked_q) begin
                lock_cnt_q <= lock_cnt_q - 1'b1;
                if (lock_cnt_q == LOCK_ONE) begin
                    locked_q <= 1'b0;
                end
            end else if (code_valid) begin
                if (code_match) begin
                    door_unlock_q <= 1'b1;
                    fail_cnt_q    <= '0;
                end else if (fail_cnt_q == FAIL_LAST) begin
                    fail_cnt_q <= '0;
                    locked_q   <= 1'b1;
                    lock_cnt_q <= LOCK_INIT;
                end else begin
                    fail_cnt_q <= fail_cnt_q + 1'b1;
                end
            end
        end
    end

    // Alarm holds while either sensor is high or a calamity event is still unacknowledged.
    assign alarm       = prev_q[EV_FIRE] | prev_q[EV_QUAKE] | pend_q[EV_FIRE] | pend_q[EV_QUAKE];
    assign exit_open   = alarm;
    assign srv_req     = srv_req_q;
    assign srv_event   = srv_event_q;
    assign door_unlock = door_unlock_q;
    assign locked      = locked_q;
    assign retry_err   = retry_err_q;

endmodule
